// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS datapath sharing one req/ready memory port between
// instruction fetch and data access; control comes from an external decoder.
module multicycle_datapath #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       inst_out,
    input  logic              RegDst,
    input  logic              ALUSrc_B,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              BranchNE,
    input  logic              Jump,
    input  logic [2:0]        ALU_Control,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] ALU_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              inst_done,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state;
    state_t state_n;

    logic [DATA_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rf [32];
    logic              done_q;

    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] br_off;
    logic [DATA_W-1:0] j_tgt;
    logic              taken;
    logic              retire;
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [4:0]        waddr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;

    function automatic logic [DATA_W-1:0] rf_rd(input logic [4:0] r);
        if (ZERO_REG != 0 && r == 5'd0) begin
            return '0;
        end
        return rf[r];
    endfunction

    assign imm_sx = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign b_op   = ALUSrc_B ? imm_sx : b_q;
    assign br_off = {imm_sx[DATA_W-3:0], 2'b00};
    assign j_tgt  = {pc[DATA_W-1:28], ir[25:0], 2'b00};
    assign taken  = (a_q == b_q) ^ BranchNE;

    always_comb begin
        alu_res = '0;
        unique case (ALU_Control)
            3'b000: alu_res = a_q & b_op;
            3'b001: alu_res = a_q | b_op;
            3'b010: alu_res = a_q + b_op;
            3'b011: alu_res = a_q ^ b_op;
            3'b100: alu_res = ~(a_q | b_op);
            3'b101: alu_res = b_op << ir[10:6];
            3'b110: alu_res = a_q - b_op;
            3'b111: alu_res = {{(DATA_W-1){1'b0}},
                               $signed(a_q) < $signed(b_op)};
        endcase
    end

    // Sequencer: every retiring path collapses back to FETCH.
    always_comb begin
        state_n = state;
        retire  = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        addr    = pc;
        unique case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                if (Jump || Branch) retire = 1'b1;
                else if (MemRead || MemWrite) state_n = S_MEM;
                else if (RegWrite) state_n = S_WB;
                else retire = 1'b1;
            end
            S_MEM: begin
                req  = 1'b1;
                we   = MemWrite;
                addr = alu_q;
                if (mem_ready) begin
                    if (MemRead) state_n = S_WB;
                    else retire = 1'b1;
                end
            end
            S_WB: retire = 1'b1;
            default: state_n = S_FETCH;
        endcase
        if (retire) state_n = S_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else state <= state_n;
    end

    assign waddr = RegDst ? ir[15:11] : ir[20:16];
    assign wdata = MemtoReg ? mdr : alu_q;
    assign wr_en = (state == S_WB) && RegWrite &&
                   !(ZERO_REG != 0 && waddr == 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= PC_RESET;
            ir     <= '0;
            a_q    <= '0;
            b_q    <= '0;
            alu_q  <= '0;
            mdr    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            done_q <= retire;
            unique case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + DATA_W'(4);
                    end
                end
                S_DECODE: begin
                    a_q <= rf_rd(ir[25:21]);
                    b_q <= rf_rd(ir[20:16]);
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (Jump) pc <= j_tgt;
                    else if (Branch && taken) pc <= pc + br_off;
                end
                S_MEM: begin
                    if (mem_ready && MemRead) mdr <= mem_rdata;
                end
                S_WB: begin
                    if (wr_en) rf[waddr] <= wdata;
                end
                default: ;
            endcase
        end
    end

    // Reset must silence the port at once, even mid-access.
    assign mem_req   = req & rst_n;
    assign mem_we    = we & rst_n;
    assign mem_addr  = addr;
    assign mem_wdata = b_q;
    assign inst_out  = ir;
    assign PC_out    = pc;
    assign ALU_out   = alu_q;
    assign Data_out  = b_q;
    assign inst_done = done_q;
    assign dbg_rdata = rf_rd(dbg_raddr);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: memory responder, external decoder and
// an instruction-level reference model checked at every retire.
module tb_multicycle_datapath;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_req, mem_we, mem_ready;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] inst_out;
    logic RegDst, ALUSrc_B, MemtoReg, RegWrite, MemRead;
    logic MemWrite, Branch, BranchNE, Jump;
    logic [2:0] ALU_Control;
    logic [W-1:0] PC_out, ALU_out, Data_out, dbg_rdata;
    logic inst_done;
    logic [4:0] dbg_raddr = 5'd0;

    logic z_req, z_we, z_done;
    logic [W-1:0] z_addr, z_wdata, z_pc, z_alu, z_data, z_dbg;
    logic [31:0] z_inst;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int lat = 1;
    int cnt = 0;
    int prev_cyc = 0;
    bit have_prev = 0;
    int we_cycles = 0;
    logic [31:0] we_addr, we_data;

    bit [31:0] mem [bit [29:0]];
    bit [31:0] ref_mem [bit [29:0]];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    multicycle_datapath #(.DATA_W(W), .PC_RESET('0), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .inst_out(inst_out),
        .RegDst(RegDst), .ALUSrc_B(ALUSrc_B), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .BranchNE(BranchNE), .Jump(Jump),
        .ALU_Control(ALU_Control), .PC_out(PC_out), .ALU_out(ALU_out),
        .Data_out(Data_out), .inst_done(inst_done),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    // Runs in lockstep with dut; only its r0 behaviour is examined.
    multicycle_datapath #(.DATA_W(W), .PC_RESET('0), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .mem_req(z_req), .mem_we(z_we), .mem_addr(z_addr),
        .mem_wdata(z_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .inst_out(z_inst),
        .RegDst(RegDst), .ALUSrc_B(ALUSrc_B), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .BranchNE(BranchNE), .Jump(Jump),
        .ALU_Control(ALU_Control), .PC_out(z_pc), .ALU_out(z_alu),
        .Data_out(z_data), .inst_done(z_done),
        .dbg_raddr(dbg_raddr), .dbg_rdata(z_dbg)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cycle++;

    function automatic bit [31:0] rdm(input bit [29:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    function automatic bit [31:0] rdr(input bit [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    // Memory: ready after lat cycles of a held request.
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            cnt = 0;
            mem_ready = 1'b0;
        end else begin
            if (mem_ready) cnt = 0;
            cnt++;
            mem_ready = (cnt >= lat);
        end
        mem_rdata = rdm(mem_addr[31:2]);
        if (rst_n && mem_we) begin
            we_cycles++;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_we && mem_ready)
            mem[mem_addr[31:2]] = mem_wdata;
    end

    // External decoder
    always_comb begin
        RegDst = 0; ALUSrc_B = 0; MemtoReg = 0; RegWrite = 0;
        MemRead = 0; MemWrite = 0; Branch = 0; BranchNE = 0;
        Jump = 0; ALU_Control = 3'b010;
        case (inst_out[31:26])
            6'h00: begin
                RegDst = 1; RegWrite = 1;
                case (inst_out[5:0])
                    6'h20: ALU_Control = 3'b010;
                    6'h22: ALU_Control = 3'b110;
                    6'h24: ALU_Control = 3'b000;
                    6'h25: ALU_Control = 3'b001;
                    6'h26: ALU_Control = 3'b011;
                    6'h27: ALU_Control = 3'b100;
                    6'h2a: ALU_Control = 3'b111;
                    default: ALU_Control = 3'b101;
                endcase
            end
            6'h08: begin ALUSrc_B = 1; RegWrite = 1; end
            6'h23: begin
                ALUSrc_B = 1; MemRead = 1; MemtoReg = 1; RegWrite = 1;
            end
            6'h2b: begin ALUSrc_B = 1; MemWrite = 1; end
            6'h04: Branch = 1;
            6'h05: begin Branch = 1; BranchNE = 1; end
            6'h02: Jump = 1;
            default: ;
        endcase
    end

    function automatic logic [31:0] r_i(int rs, int rt, int rd,
                                        int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_i(logic [31:0] tgt);
        return {6'd2, tgt[27:2]};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[31:2]] = w;
        ref_mem[a[31:2]] = w;
    endtask

    // ISA-level model of one instruction; returns its expected cycle count.
    task automatic model_step(output int cyc);
        logic [31:0] ins, sx, a, b, res, ea;
        int rd;
        bit wr;
        ins = rdr(m_pc[31:2]);
        m_pc = m_pc + 4;
        a = m_reg[ins[25:21]];
        b = m_reg[ins[20:16]];
        sx = {{16{ins[15]}}, ins[15:0]};
        wr = 0; rd = 0; res = 0; ea = 0;
        cyc = lat + 3;
        case (ins[31:26])
            6'h00: begin
                wr = 1; rd = int'(ins[15:11]);
                case (ins[5:0])
                    6'h20: res = a + b;
                    6'h22: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2a: res = ($signed(a) < $signed(b)) ? 1 : 0;
                    default: res = b << ins[10:6];
                endcase
            end
            6'h08: begin wr = 1; rd = int'(ins[20:16]); res = a + sx; end
            6'h23: begin
                wr = 1; rd = int'(ins[20:16]);
                ea = a + sx; res = rdr(ea[31:2]);
                cyc = 2 * lat + 3;
            end
            6'h2b: begin
                ea = a + sx; ref_mem[ea[31:2]] = b;
                cyc = 2 * lat + 2;
            end
            6'h04: begin
                if (a == b) m_pc = m_pc + (sx << 2);
                cyc = lat + 2;
            end
            6'h05: begin
                if (a != b) m_pc = m_pc + (sx << 2);
                cyc = lat + 2;
            end
            6'h02: begin
                m_pc = {m_pc[31:28], ins[25:0], 2'b00};
                cyc = lat + 2;
            end
            default: ;
        endcase
        if (wr && rd != 0) m_reg[rd] = res;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        mem.delete();
        ref_mem.delete();
        for (int r = 0; r < 32; r++) m_reg[r] = 0;
        m_pc = 0;
        have_prev = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #10 rst_n = 1;
    endtask

    // Wait for a retire, then compare PC, registers and CPI to the model.
    task automatic step(input string nm);
        bit ok;
        int cexp, badr, i;
        bit bad;
        logic [31:0] got;
        ok = 0;
        i = 0;
        while (!ok && i < 60) begin
            @(negedge clk);
            #1;
            if (inst_done === 1'b1) ok = 1;
            i++;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s timeout: no inst_done in 60 cycles", nm);
            return;
        end
        model_step(cexp);
        tests++;
        if (PC_out !== m_pc) begin
            fails++;
            $display("FAIL %s pc: got %h want %h", nm, PC_out, m_pc);
        end
        bad = 0; badr = 0; got = 0;
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            if (!bad && dbg_rdata !== m_reg[r]) begin
                bad = 1; badr = r; got = dbg_rdata;
            end
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s r%0d: got %h want %h",
                     nm, badr, got, m_reg[badr]);
        end
        if (have_prev) begin
            tests++;
            if (cycle - prev_cyc != cexp) begin
                fails++;
                $display("FAIL %s cpi: got %0d want %0d",
                         nm, cycle - prev_cyc, cexp);
            end
        end
        prev_cyc = cycle;
        have_prev = 1;
    endtask

    task automatic test_reset();
        do_reset();
        put(0, i_i(8, 0, 1, 5));
        #1;
        tests++;
        if (mem_req !== 0 || mem_we !== 0) begin
            fails++;
            $display("FAIL reset port: req %b we %b want 0 0",
                     mem_req, mem_we);
        end
        tests++;
        if (PC_out !== 0 || ALU_out !== 0 || inst_out !== 0) begin
            fails++;
            $display("FAIL reset regs: pc %h alu %h ir %h want 0",
                     PC_out, ALU_out, inst_out);
        end
        tests++;
        if (inst_done !== 0) begin
            fails++;
            $display("FAIL reset done: got %b want 0", inst_done);
        end
        release_reset();
        #1;
        tests++;
        if (mem_req !== 1 || mem_addr !== 0) begin
            fails++;
            $display("FAIL first fetch: req %b addr %h want 1 0",
                     mem_req, mem_addr);
        end
        step("reset_addi");
    endtask

    task automatic test_alu_chain();
        do_reset();
        lat = 1;
        put(32'h0, r_i(0, 0, 1, 0, 6'h27));
        put(32'h4, r_i(0, 1, 2, 0, 6'h2a));
        put(32'h8, r_i(2, 2, 3, 0, 6'h20));
        release_reset();
        step("nor");
        step("slt");
        step("add");
        dbg_raddr = 1; #1;
        tests++;
        if (dbg_rdata !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL chain r1: got %h want ffffffff", dbg_rdata);
        end
        dbg_raddr = 2; #1;
        tests++;
        if (dbg_rdata !== 0) begin
            fails++;
            $display("FAIL chain r2: got %h want 0", dbg_rdata);
        end
    endtask

    task automatic test_load_store();
        do_reset();
        lat = 3;
        put(32'h14, 32'h55555555);
        put(32'h0, i_i(8, 0, 4, 1));
        put(32'h4, i_i(6'h23, 0, 5, 32'h14));
        put(32'h8, i_i(6'h2b, 0, 5, 32'h30));
        release_reset();
        step("ls_addi");
        step("lw");
        dbg_raddr = 5; #1;
        tests++;
        if (dbg_rdata !== 32'h55555555) begin
            fails++;
            $display("FAIL lw r5: got %h want 55555555", dbg_rdata);
        end
        we_cycles = 0;
        step("sw");
        tests++;
        if (we_cycles != 3 || we_addr !== 32'h30 ||
            we_data !== 32'h55555555) begin
            fails++;
            $display("FAIL sw port: we %0d addr %h data %h want 3 30 55555555",
                     we_cycles, we_addr, we_data);
        end
        tests++;
        if (rdm(30'h0C) !== 32'h55555555) begin
            fails++;
            $display("FAIL sw mem: got %h want 55555555", rdm(30'h0C));
        end
    endtask

    task automatic test_reset_mid_mem();
        bit seen;
        bit bad;
        int i;
        do_reset();
        lat = 3;
        put(32'h40, 32'hDEADBEEF);
        put(32'h0, i_i(8, 0, 5, 32'h77));
        put(32'h4, i_i(6'h2b, 0, 5, 32'h40));
        release_reset();
        step("rm_addi");
        seen = 0;
        i = 0;
        while (!seen && i < 30) begin
            @(negedge clk);
            #1;
            if (mem_we === 1'b1) seen = 1;
            i++;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL mid_mem: store never reached MEM");
        end
        #10 rst_n = 0;
        #1;
        tests++;
        if (mem_req !== 0 || mem_we !== 0) begin
            fails++;
            $display("FAIL mid_mem port: req %b we %b want 0 0",
                     mem_req, mem_we);
        end
        repeat (2) @(posedge clk);
        release_reset();
        #1;
        tests++;
        if (PC_out !== 0 || mem_addr !== 0 || inst_done !== 0) begin
            fails++;
            $display("FAIL mid_mem restart: pc %h addr %h done %b want 0",
                     PC_out, mem_addr, inst_done);
        end
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            if (dbg_rdata !== 0) bad = 1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL mid_mem regs: nonzero register after reset");
        end
        tests++;
        if (rdm(30'h10) !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL mid_mem write: got %h want deadbeef",
                     rdm(30'h10));
        end
    endtask

    task automatic test_branch();
        do_reset();
        lat = 1;
        put(32'h00, j_i(32'h20));
        put(32'h20, i_i(8, 0, 2, 7));
        put(32'h24, i_i(8, 0, 5, 9));
        put(32'h28, i_i(4, 2, 5, 5));
        put(32'h2C, i_i(5, 2, 5, 32'hFFFB));
        put(32'h1C, j_i(32'h80));
        put(32'h80, j_i(32'h0));
        release_reset();
        step("j20");
        step("br_addi2");
        step("br_addi5");
        step("beq");
        tests++;
        if (PC_out !== 32'h2C) begin
            fails++;
            $display("FAIL beq pc: got %h want 2c", PC_out);
        end
        step("bne");
        tests++;
        if (PC_out !== 32'h1C) begin
            fails++;
            $display("FAIL bne pc: got %h want 1c", PC_out);
        end
        step("j80");
        step("j0");
        tests++;
        if (PC_out !== 0) begin
            fails++;
            $display("FAIL j0 pc: got %h want 0", PC_out);
        end
    endtask

    task automatic test_r0();
        do_reset();
        lat = 1;
        put(32'h0, i_i(8, 0, 1, 32'h123));
        put(32'h4, r_i(1, 1, 0, 0, 6'h20));
        release_reset();
        step("r0_addi");
        step("r0_add");
        dbg_raddr = 0; #1;
        tests++;
        if (dbg_rdata !== 0) begin
            fails++;
            $display("FAIL r0 hard: got %h want 0", dbg_rdata);
        end
        tests++;
        if (z_dbg !== 32'h246) begin
            fails++;
            $display("FAIL r0 plain: got %h want 246", z_dbg);
        end
    endtask

    task automatic test_sll_xor_wrap();
        do_reset();
        lat = 1;
        put(32'h00, i_i(8, 0, 1, 15));
        put(32'h04, r_i(0, 1, 1, 4, 6'h00));
        put(32'h08, r_i(1, 1, 1, 0, 6'h26));
        put(32'h0C, i_i(8, 0, 6, 1));
        put(32'h10, i_i(5, 6, 0, 32'hFFFA));
        put(32'hFFFFFFFC, i_i(8, 0, 7, 3));
        release_reset();
        step("sx_addi");
        step("sll");
        dbg_raddr = 1; #1;
        tests++;
        if (dbg_rdata !== 32'hF0) begin
            fails++;
            $display("FAIL sll r1: got %h want f0", dbg_rdata);
        end
        step("xor");
        step("sx_addi6");
        step("bne_wrap");
        tests++;
        if (PC_out !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL bne_wrap pc: got %h want fffffffc", PC_out);
        end
        step("pc_wrap");
        tests++;
        if (PC_out !== 0) begin
            fails++;
            $display("FAIL pc_wrap: got %h want 0", PC_out);
        end
    endtask

    task automatic test_random();
        int fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                        6'h26, 6'h27, 6'h2a, 6'h00};
        int k, fn;
        bit bad;
        logic [31:0] w;
        for (int run = 0; run < 3; run++) begin
            do_reset();
            lat = int'($urandom_range(1, 3));
            for (int d = 0; d < 8; d++) put(32'h200 + 4 * d, $urandom);
            for (int a = 0; a < 80; a++) begin
                k = int'($urandom_range(0, 9));
                fn = fns[$urandom_range(0, 7)];
                if (k <= 4)
                    w = r_i(fn == 0 ? 0 : int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)),
                            fn == 0 ? int'($urandom_range(0, 31)) : 0,
                            fn);
                else if (k <= 6)
                    w = i_i(8, int'($urandom_range(0, 7)),
                            int'($urandom_range(1, 7)),
                            int'($urandom_range(0, 65535)));
                else if (k == 7)
                    w = i_i(6'h23, 0, int'($urandom_range(1, 7)),
                            32'h200 + 4 * int'($urandom_range(0, 7)));
                else if (k == 8)
                    w = i_i(6'h2b, 0, int'($urandom_range(0, 7)),
                            32'h200 + 4 * int'($urandom_range(0, 7)));
                else
                    w = i_i(int'($urandom_range(4, 5)),
                            int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 2)));
                put(32'(4 * a), w);
            end
            release_reset();
            for (int s = 0; s < 25; s++) step($sformatf("rnd%0d_%0d", run, s));
            bad = 0;
            for (int d = 0; d < 8; d++)
                if (rdm(30'(32'h80 + d)) !== rdr(30'(32'h80 + d))) bad = 1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL rnd%0d data memory differs from model", run);
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_chain();
        test_load_store();
        test_reset_mid_mem();
        test_branch();
        test_r0();
        test_sll_xor_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
